sr_ram_ctrl: RTL and testbench

//   Address/sequencing controller that turns a simple dual-port block RAM into a run-time-length

---
 rtl/sr_ram_ctrl_pkg.sv | 18 +
 rtl/sr_ram_sdp.sv | 41 ++++
 rtl/sr_ram_ctrl.sv | 110 +++++++++++
 tb/tb_sr_ram_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/sr_ram_ctrl_pkg.sv
// Shared definitions for the RAM-based delay-line controller: FSM states,
// read-latency limits and the delay-length legality check.
package sr_ram_ctrl_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } sr_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // A ring of Len+1 words must fit in the RAM, and a zero delay is meaningless.
    function automatic logic len_legal(input int len, input int depth);
        return (len > 0) && (len < depth);
    endfunction

endpackage

// File: rtl/sr_ram_sdp.sv
// Inferred simple dual-port block RAM, one write port and one registered read
// port, with optional extra output register stages to model RD_LAT.
module sr_ram_sdp #(
    parameter int DSIZE  = 16,
    parameter int WDEPTH = 800,
    parameter int ASIZE  = $clog2(WDEPTH),
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [ASIZE-1:0] wr_addr,
    input  logic [DSIZE-1:0] wr_data,
    input  logic             rd_en,
    input  logic [ASIZE-1:0] rd_addr,
    output logic [DSIZE-1:0] rd_data
);

    logic [DSIZE-1:0] mem [WDEPTH];
    logic [DSIZE-1:0] rd_stage_reg [RD_LAT];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_stage_reg[0] <= mem[rd_addr];
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < RD_LAT; gi++) begin : g_rd_pipe
            always_ff @(posedge clk) begin
                rd_stage_reg[gi] <= rd_stage_reg[gi-1];
            end
        end
    endgenerate

    assign rd_data = rd_stage_reg[RD_LAT-1];

endmodule

// File: rtl/sr_ram_ctrl.sv
// Address/sequencing controller that turns an external simple dual-port RAM
// into a run-time-programmable delay line: circular pointer, fill FSM, valid pipe.
module sr_ram_ctrl
    import sr_ram_ctrl_pkg::*;
#(
    parameter int DSIZE       = 16,
    parameter int WDEPTH      = 800,
    parameter int ASIZE       = $clog2(WDEPTH),
    parameter int RD_LAT      = 1,
    parameter int DEFAULT_LEN = WDEPTH - 1
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             cfg_load,
    input  logic [ASIZE-1:0] cfg_len,
    output logic             cfg_err,
    input  logic [DSIZE-1:0] Din,
    input  logic             din_valid,
    output logic             ram_wr_en,
    output logic [ASIZE-1:0] ram_wr_addr,
    output logic [DSIZE-1:0] ram_wr_data,
    output logic             ram_rd_en,
    output logic [ASIZE-1:0] ram_rd_addr,
    input  logic [DSIZE-1:0] ram_rd_data,
    output logic [DSIZE-1:0] Q,
    output logic             q_valid,
    output logic             primed
);

    localparam int VLAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                          (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    sr_state_e        state_reg, state_next;
    logic [ASIZE-1:0] len_reg, len_next;
    logic [ASIZE-1:0] ptr_reg, ptr_next, ptr_inc;
    logic [ASIZE-1:0] fill_reg, fill_next, fill_inc;
    logic [VLAT-1:0]  vpipe_reg, vpipe_next, vpipe_shift;
    logic             cfg_err_reg;
    logic             load_ok, load_bad, accept;

    assign load_ok  = cfg_load && len_legal(int'(cfg_len), WDEPTH);
    assign load_bad = cfg_load && !len_legal(int'(cfg_len), WDEPTH);
    // A legal load steals the cycle: the coincident sample is dropped.
    assign accept   = din_valid && !load_ok && !Reset;

    assign ptr_inc  = (ptr_reg == len_reg) ? '0 : ptr_reg + ASIZE'(1);
    assign fill_inc = fill_reg + ASIZE'(1);

    // Only reads issued in RUN return a sample that was actually written.
    assign vpipe_shift[0] = accept && (state_reg == ST_RUN);
    genvar gi;
    generate
        for (gi = 1; gi < VLAT; gi++) begin : g_vpipe
            assign vpipe_shift[gi] = vpipe_reg[gi-1];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        ptr_next   = ptr_reg;
        fill_next  = fill_reg;
        vpipe_next = vpipe_shift;
        if (load_ok) begin
            len_next   = cfg_len;
            ptr_next   = '0;
            fill_next  = '0;
            state_next = ST_FILL;
            vpipe_next = '0;
        end else if (accept) begin
            ptr_next = ptr_inc;
            if (state_reg == ST_FILL) begin
                fill_next = fill_inc;
                if (fill_inc == len_reg) begin
                    state_next = ST_RUN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_reg   <= ST_FILL;
            len_reg     <= ASIZE'(DEFAULT_LEN);
            ptr_reg     <= '0;
            fill_reg    <= '0;
            vpipe_reg   <= '0;
            cfg_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            len_reg     <= len_next;
            ptr_reg     <= ptr_next;
            fill_reg    <= fill_next;
            vpipe_reg   <= vpipe_next;
            cfg_err_reg <= load_bad;
        end
    end

    assign ram_wr_en   = accept;
    assign ram_wr_addr = ptr_reg;
    assign ram_wr_data = Din;
    assign ram_rd_en   = accept;
    assign ram_rd_addr = ptr_inc;

    assign q_valid = vpipe_reg[VLAT-1];
    assign Q       = q_valid ? ram_rd_data : '0;
    assign primed  = (state_reg == ST_RUN);
    assign cfg_err = cfg_err_reg;

endmodule

// File: tb/tb_sr_ram_ctrl.sv
// Self-checking bench: controller plus inferred RAM, checked against a
// history-queue model of "sample accepted Len accepts ago".
module tb_sr_ram_ctrl;

    localparam int DSIZE  = 16;
    localparam int WDEPTH = 800;
    localparam int ASIZE  = 10;

    logic             clk = 1'b0;
    logic             Reset = 1'b1;
    logic             cfg_load = 1'b0;
    logic [ASIZE-1:0] cfg_len = '0;
    logic             cfg_err;
    logic [DSIZE-1:0] Din = '0;
    logic             din_valid = 1'b0;
    logic             ram_wr_en, ram_rd_en;
    logic [ASIZE-1:0] ram_wr_addr, ram_rd_addr;
    logic [DSIZE-1:0] ram_wr_data, ram_rd_data;
    logic [DSIZE-1:0] Q;
    logic             q_valid, primed;

    always #5 clk = ~clk;

    sr_ram_ctrl #(.DSIZE(DSIZE), .WDEPTH(WDEPTH), .RD_LAT(1)) dut (
        .clk(clk), .Reset(Reset), .cfg_load(cfg_load), .cfg_len(cfg_len), .cfg_err(cfg_err),
        .Din(Din), .din_valid(din_valid),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .Q(Q), .q_valid(q_valid), .primed(primed)
    );

    sr_ram_sdp #(.DSIZE(DSIZE), .WDEPTH(WDEPTH), .RD_LAT(1)) u_ram (
        .clk(clk), .wr_en(ram_wr_en), .wr_addr(ram_wr_addr), .wr_data(ram_wr_data),
        .rd_en(ram_rd_en), .rd_addr(ram_rd_addr), .rd_data(ram_rd_data)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: samples accepted since the last load/reset, current delay.
    logic [DSIZE-1:0] hist[$];
    int               cur_len = WDEPTH - 1;
    int               acc_cnt = 0;
    logic             exp_qv = 1'b0, exp_primed = 1'b0, exp_err = 1'b0;
    logic [DSIZE-1:0] exp_q = '0;
    logic [DSIZE-1:0] ramp = '0;

    // One clock cycle: drive at negedge, check combinational RAM controls,
    // advance the model, then check registered outputs at the next negedge.
    task automatic step(input logic dv, input logic [DSIZE-1:0] d, input logic ld,
                        input logic [ASIZE-1:0] ln, input logic rst);
        logic legal, acc;
        Reset = rst; cfg_load = ld; cfg_len = ln; din_valid = dv; Din = d;
        #1;
        legal = (ln != 0) && (int'(ln) < WDEPTH);
        acc   = dv && !(ld && legal) && !rst;
        check("wr_en", 32'(ram_wr_en), 32'(acc));
        check("rd_en", 32'(ram_rd_en), 32'(acc));
        if (acc) begin
            check("wr_addr", 32'(ram_wr_addr), 32'(acc_cnt % (cur_len + 1)));
            check("rd_addr", 32'(ram_rd_addr), 32'((acc_cnt + 1) % (cur_len + 1)));
            check("addr_distinct", 32'(ram_wr_addr != ram_rd_addr), 32'(1));
            check("wr_data", 32'(ram_wr_data), 32'(d));
        end
        if (rst) begin
            cur_len = WDEPTH - 1; acc_cnt = 0; hist.delete();
            exp_qv = 1'b0; exp_q = '0; exp_err = 1'b0;
        end else begin
            exp_err = ld && !legal;
            exp_qv = 1'b0; exp_q = '0;
            if (ld && legal) begin
                cur_len = int'(ln); acc_cnt = 0; hist.delete();
            end else if (acc) begin
                if (acc_cnt >= cur_len) begin
                    exp_qv = 1'b1;
                    exp_q  = hist[acc_cnt - cur_len];
                end
                hist.push_back(d);
                acc_cnt++;
            end
        end
        exp_primed = (acc_cnt >= cur_len);
        @(negedge clk);
        check("q_valid", 32'(q_valid), 32'(exp_qv));
        check("Q", 32'(Q), 32'(exp_q));
        check("primed", 32'(primed), 32'(exp_primed));
        check("cfg_err", 32'(cfg_err), 32'(exp_err));
        ramp++;
    endtask

    task automatic report(input string name);
        $display("scenario %s: %0d/%0d checks so far", name, n_pass, n_checks);
    endtask

    initial begin
        @(negedge clk);
        // 1: short delay of 4 on a ramp
        step(1'b0, '0, 1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1, ASIZE'(4), 1'b0);
        ramp = '0;
        for (int i = 0; i < 20; i++) step(1'b1, ramp, 1'b0, '0, 1'b0);
        report("len4_ramp");

        // 2: default length, long ramp crossing the ring wrap twice
        step(1'b0, '0, 1'b0, '0, 1'b1);
        ramp = '0;
        for (int i = 0; i < 2000; i++) step(1'b1, ramp, 1'b0, '0, 1'b0);
        report("default_len_ramp");

        // 3: gapped input 1,0,0,1 with Len=5
        step(1'b0, '0, 1'b1, ASIZE'(5), 1'b0);
        for (int i = 0; i < 48; i++)
            step((i % 4 == 0) || (i % 4 == 3), ramp, 1'b0, '0, 1'b0);
        report("gapped_len5");

        // 4: legal reload mid-RUN coincident with a valid sample
        step(1'b1, ramp, 1'b1, ASIZE'(10), 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, ramp, 1'b0, '0, 1'b0);
        report("reload_len10");

        // 5: illegal lengths with coincident samples
        step(1'b1, ramp, 1'b1, ASIZE'(0), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, ramp, 1'b0, '0, 1'b0);
        step(1'b1, ramp, 1'b1, ASIZE'(800), 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, ramp, 1'b0, '0, 1'b0);
        report("illegal_len");

        // 6: one-cycle reset mid-RUN, then refill at the default length
        step(1'b1, ramp, 1'b0, '0, 1'b1);
        for (int i = 0; i < 900; i++) step(1'b1, ramp, 1'b0, '0, 1'b0);
        report("reset_midrun");

        // 7: randomized data, gaps, loads and rare resets
        step(1'b0, '0, 1'b1, ASIZE'(3), 1'b0);
        for (int i = 0; i < 800; i++) begin
            int unsigned r;
            logic [ASIZE-1:0] ln;
            r  = $urandom_range(0, 99);
            ln = (r == 1) ? (($urandom_range(0, 1) == 0) ? ASIZE'(0) : ASIZE'($urandom_range(800, 1023)))
                          : ASIZE'($urandom_range(1, 20));
            step($urandom_range(0, 2) != 0, DSIZE'($urandom), (r >= 1) && (r <= 4), ln, r == 0);
        end
        report("random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
